// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator.
// Holds the default 640x480@60 timing constants, the derived line/frame totals,
// the coordinate type, the phase enumerations and a wrapping-increment helper.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned VGA_CLK_DIV  = 4;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNCP, H_BACK} h_phase_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNCP, V_BACK} v_phase_t;

  // Counter increment that wraps to zero after the last value.
  function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
    return (v == last) ? '0 : v + coord_t'(1);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate tick divider.
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous reset, active low
//   o_tick     combinational tick, high in the last clk of each CLK_DIV period
//   o_pclk_en  registered tick, high in the clk after o_tick
module pixel_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = VGA_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_reset_n,
  output logic o_tick,
  output logic o_pclk_en
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LP_DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_pclk_en;
  logic          w_tick;

  assign w_tick    = (r_div_cnt == LP_DIV_LAST);
  assign o_tick    = w_tick;
  assign o_pclk_en = r_pclk_en;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_div_cnt <= '0;
      r_pclk_en <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_pclk_en <= w_tick;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// Ports:
//   i_clk, i_reset_n  system clock, synchronous active-low reset
//   o_pclk_en         one-clk pixel tick, aligned with each coordinate update
//   o_x_pixel         horizontal counter 0..H_TOTAL-1
//   o_y_pixel         vertical counter 0..V_TOTAL-1
//   o_h_sync          horizontal sync, active low
//   o_v_sync          vertical sync, active low
//   o_de              data enable, high inside the visible area
//   o_line_start      one-clk pulse when x moves to 0
//   o_frame_start     one-clk pulse when (x,y) moves to (0,0)
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  output logic         o_pclk_en,
  output logic [9:0]   o_x_pixel,
  output logic [9:0]   o_y_pixel,
  output logic         o_h_sync,
  output logic         o_v_sync,
  output logic         o_de,
  output logic         o_line_start,
  output logic         o_frame_start
);

  localparam int unsigned LP_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned LP_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // First coordinate of each phase, plus the last coordinate of the line/frame.
  localparam coord_t LP_X_FP   = coord_t'(H_ACTIVE);
  localparam coord_t LP_X_SYNC = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t LP_X_BP   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t LP_X_LAST = coord_t'(LP_H_TOTAL - 1);
  localparam coord_t LP_Y_FP   = coord_t'(V_ACTIVE);
  localparam coord_t LP_Y_SYNC = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t LP_Y_BP   = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t LP_Y_LAST = coord_t'(LP_V_TOTAL - 1);

  logic     w_tick;
  logic     w_pclk_en;
  logic     w_h_wrap;
  logic     w_v_wrap;
  coord_t   w_x_next;
  coord_t   w_y_next;
  h_phase_t r_h_phase, w_h_phase_d;
  v_phase_t r_v_phase, w_v_phase_d;
  coord_t   r_x;
  coord_t   r_y;
  logic     r_h_sync;
  logic     r_v_sync;
  logic     r_de;
  logic     r_line_start;
  logic     r_frame_start;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_tick    (w_tick),
    .o_pclk_en (w_pclk_en)
  );

  always_comb begin
    w_h_wrap = (r_x == LP_X_LAST);
    w_v_wrap = (r_y == LP_Y_LAST);
    w_x_next = wrap_inc(r_x, LP_X_LAST);
    w_y_next = wrap_inc(r_y, LP_Y_LAST);
  end

  // Phase transitions are decided on the coordinate about to be loaded, so the
  // registered decode below lines up with the counters on the same edge.
  always_comb begin
    w_h_phase_d = r_h_phase;
    if (w_tick) begin
      case (r_h_phase)
        H_ACT:   if (w_x_next == LP_X_FP)   w_h_phase_d = H_FRONT;
        H_FRONT: if (w_x_next == LP_X_SYNC) w_h_phase_d = H_SYNCP;
        H_SYNCP: if (w_x_next == LP_X_BP)   w_h_phase_d = H_BACK;
        H_BACK:  if (w_h_wrap)              w_h_phase_d = H_ACT;
        default:                            w_h_phase_d = H_BACK;
      endcase
    end
  end

  always_comb begin
    w_v_phase_d = r_v_phase;
    if (w_tick && w_h_wrap) begin
      case (r_v_phase)
        V_ACT:   if (w_y_next == LP_Y_FP)   w_v_phase_d = V_FRONT;
        V_FRONT: if (w_y_next == LP_Y_SYNC) w_v_phase_d = V_SYNCP;
        V_SYNCP: if (w_y_next == LP_Y_BP)   w_v_phase_d = V_BACK;
        V_BACK:  if (w_v_wrap)              w_v_phase_d = V_ACT;
        default:                            w_v_phase_d = V_BACK;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_h_phase <= H_BACK;
      r_v_phase <= V_BACK;
    end else begin
      r_h_phase <= w_h_phase_d;
      r_v_phase <= w_v_phase_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_x           <= LP_X_LAST;
      r_y           <= LP_Y_LAST;
      r_h_sync      <= 1'b1;
      r_v_sync      <= 1'b1;
      r_de          <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_tick) begin
        r_x <= w_x_next;
        if (w_h_wrap) begin
          r_y <= w_y_next;
        end
      end
      // Phase next-state only moves on a tick, so these hold between ticks.
      r_h_sync      <= (w_h_phase_d != H_SYNCP);
      r_v_sync      <= (w_v_phase_d != V_SYNCP);
      r_de          <= (w_h_phase_d == H_ACT) && (w_v_phase_d == V_ACT);
      r_line_start  <= w_tick && w_h_wrap;
      r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
    end
  end

  assign o_pclk_en     = w_pclk_en;
  assign o_x_pixel     = r_x;
  assign o_y_pixel     = r_y;
  assign o_h_sync      = r_h_sync;
  assign o_v_sync      = r_v_sync;
  assign o_de          = r_de;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing (A), CLK_DIV=2 (B) and a
// tiny geometry with CLK_DIV=2 (C) so a whole frame fits in a short run.
module tb_vga_timing_gen;

  // Geometry of instance C: H_TOTAL=15, V_TOTAL=10.
  localparam int unsigned C_H_ACTIVE = 8;
  localparam int unsigned C_H_FP     = 2;
  localparam int unsigned C_H_SYNC   = 3;
  localparam int unsigned C_H_BP     = 2;
  localparam int unsigned C_V_ACTIVE = 6;
  localparam int unsigned C_V_FP     = 1;
  localparam int unsigned C_V_SYNC   = 2;
  localparam int unsigned C_V_BP     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   sel = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic       pclk_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic       pclk_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic       pclk_c, hs_c, vs_c, de_c, ls_c, fs_c;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;

  logic       m_pclk, m_hs, m_vs, m_de, m_ls, m_fs;
  logic [9:0] m_x, m_y;

  always #5 clk = ~clk;

  vga_timing_gen u_dut_a (
    .i_clk (clk), .i_reset_n (rst_n), .o_pclk_en (pclk_a), .o_x_pixel (x_a),
    .o_y_pixel (y_a), .o_h_sync (hs_a), .o_v_sync (vs_a), .o_de (de_a),
    .o_line_start (ls_a), .o_frame_start (fs_a)
  );

  vga_timing_gen #(.CLK_DIV (2)) u_dut_b (
    .i_clk (clk), .i_reset_n (rst_n), .o_pclk_en (pclk_b), .o_x_pixel (x_b),
    .o_y_pixel (y_b), .o_h_sync (hs_b), .o_v_sync (vs_b), .o_de (de_b),
    .o_line_start (ls_b), .o_frame_start (fs_b)
  );

  vga_timing_gen #(
    .CLK_DIV (2), .H_ACTIVE (C_H_ACTIVE), .H_FP (C_H_FP), .H_SYNC (C_H_SYNC),
    .H_BP (C_H_BP), .V_ACTIVE (C_V_ACTIVE), .V_FP (C_V_FP), .V_SYNC (C_V_SYNC),
    .V_BP (C_V_BP)
  ) u_dut_c (
    .i_clk (clk), .i_reset_n (rst_n), .o_pclk_en (pclk_c), .o_x_pixel (x_c),
    .o_y_pixel (y_c), .o_h_sync (hs_c), .o_v_sync (vs_c), .o_de (de_c),
    .o_line_start (ls_c), .o_frame_start (fs_c)
  );

  always_comb begin
    m_pclk = pclk_a; m_x = x_a; m_y = y_a; m_hs = hs_a; m_vs = vs_a;
    m_de = de_a; m_ls = ls_a; m_fs = fs_a;
    if (sel == 1) begin
      m_pclk = pclk_b; m_x = x_b; m_y = y_b; m_hs = hs_b; m_vs = vs_b;
      m_de = de_b; m_ls = ls_b; m_fs = fs_b;
    end else if (sel == 2) begin
      m_pclk = pclk_c; m_x = x_c; m_y = y_c; m_hs = hs_c; m_vs = vs_c;
      m_de = de_c; m_ls = ls_c; m_fs = fs_c;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
  endtask

  // Clocks until the next pclk_en, counting the first edge stepped over.
  task automatic wait_pclk(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!m_pclk && n < 50);
  endtask

  // Starting on a line_start clock, run to the next line_start.
  task automatic measure_line(output int clks, output int de_t, output int hs_t,
                              output int hs_first, output int hs_last);
    clks = 0; de_t = 0; hs_t = 0; hs_first = -1; hs_last = -1;
    do begin
      if (m_pclk) begin
        if (m_de) de_t++;
        if (!m_hs) begin
          if (hs_first < 0) hs_first = int'(m_x);
          hs_last = int'(m_x);
          hs_t++;
        end
      end
      step();
      clks++;
    end while (!m_ls && clks < 4000);
  endtask

  initial begin
    int n, clks, de_t, hs_t, hs_first, hs_last, vs_t, vs_first, vs_last, de_late;
    int px, py, pde, pvs;
    bit found;

    // ---------------- Instance A: default timing ----------------
    sel = 0;
    do_reset(10);
    chk("rst_x", 32'(m_x), 799);
    chk("rst_y", 32'(m_y), 524);
    chk("rst_hs", 32'(m_hs), 1);
    chk("rst_vs", 32'(m_vs), 1);
    chk("rst_de", 32'(m_de), 0);
    chk("rst_pclk", 32'(m_pclk), 0);
    chk("rst_ls", 32'(m_ls), 0);
    chk("rst_fs", 32'(m_fs), 0);

    rst_n = 1'b1;
    wait_pclk(n);
    chk("a_first_pclk_clks", 32'(n), 4);
    chk("a_first_x", 32'(m_x), 0);
    chk("a_first_y", 32'(m_y), 0);
    chk("a_first_fs", 32'(m_fs), 1);
    chk("a_first_ls", 32'(m_ls), 1);
    chk("a_first_de", 32'(m_de), 1);
    chk("a_first_hs", 32'(m_hs), 1);
    chk("a_first_vs", 32'(m_vs), 1);

    step();
    chk("a_pclk_one_clk", 32'(m_pclk), 0);
    chk("a_fs_one_clk", 32'(m_fs), 0);
    chk("a_ls_one_clk", 32'(m_ls), 0);
    chk("a_x_holds", 32'(m_x), 0);

    // Rewind to the line_start clock of line 0 is not possible; restart cleanly.
    do_reset(2);
    rst_n = 1'b1;
    wait_pclk(n);
    measure_line(clks, de_t, hs_t, hs_first, hs_last);
    chk("a_line_clks", 32'(clks), 3200);
    chk("a_line_de_ticks", 32'(de_t), 640);
    chk("a_line_hs_ticks", 32'(hs_t), 96);
    chk("a_line_hs_first", 32'(hs_first), 656);
    chk("a_line_hs_last", 32'(hs_last), 751);
    chk("a_line1_x", 32'(m_x), 0);
    chk("a_line1_y", 32'(m_y), 1);
    chk("a_line1_fs", 32'(m_fs), 0);

    // Mid-line reset at x=300 for a single clk.
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (m_pclk && m_x == 10'd300) found = 1;
    end
    chk("a_reach_x300", 32'(found), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("a_mid_rst_x", 32'(m_x), 799);
    chk("a_mid_rst_y", 32'(m_y), 524);
    chk("a_mid_rst_hs", 32'(m_hs), 1);
    chk("a_mid_rst_vs", 32'(m_vs), 1);
    chk("a_mid_rst_de", 32'(m_de), 0);
    wait_pclk(n);
    chk("a_mid_rst_pclk_clks", 32'(n), 4);
    chk("a_mid_rst_first_x", 32'(m_x), 0);
    chk("a_mid_rst_first_y", 32'(m_y), 0);
    chk("a_mid_rst_first_fs", 32'(m_fs), 1);

    // ---------------- Instance B: CLK_DIV=2 ----------------
    sel = 1;
    do_reset(10);
    rst_n = 1'b1;
    wait_pclk(n);
    chk("b_first_pclk_clks", 32'(n), 2);
    chk("b_first_fs", 32'(m_fs), 1);
    measure_line(clks, de_t, hs_t, hs_first, hs_last);
    chk("b_line_clks", 32'(clks), 1600);
    chk("b_line_de_ticks", 32'(de_t), 640);
    chk("b_line_hs_ticks", 32'(hs_t), 96);
    chk("b_line_hs_first", 32'(hs_first), 656);
    wait_pclk(n);
    chk("b_pclk_period", 32'(n), 2);

    // ---------------- Instance C: tiny frame, natural corner wrap ----------------
    sel = 2;
    do_reset(10);
    rst_n = 1'b1;
    wait_pclk(n);
    chk("c_first_pclk_clks", 32'(n), 2);
    chk("c_first_fs", 32'(m_fs), 1);
    clks = 0; de_t = 0; vs_t = 0; vs_first = -1; vs_last = -1; de_late = 0;
    px = -1; py = -1; pde = -1; pvs = -1;
    do begin
      if (m_pclk) begin
        px = int'(m_x); py = int'(m_y); pde = int'(m_de); pvs = int'(m_vs);
        if (m_de) de_t++;
        if (m_de && m_y >= 10'(C_V_ACTIVE)) de_late++;
        if (!m_vs) begin
          if (vs_first < 0) vs_first = int'(m_y);
          vs_last = int'(m_y);
          vs_t++;
        end
      end
      step();
      clks++;
    end while (!m_fs && clks < 1000);
    chk("c_frame_clks", 32'(clks), 300);
    chk("c_frame_de_ticks", 32'(de_t), 48);
    chk("c_frame_de_late", 32'(de_late), 0);
    chk("c_frame_vs_ticks", 32'(vs_t), 30);
    chk("c_frame_vs_first_y", 32'(vs_first), 7);
    chk("c_frame_vs_last_y", 32'(vs_last), 8);
    chk("c_corner_prev_x", 32'(px), 14);
    chk("c_corner_prev_y", 32'(py), 9);
    chk("c_corner_prev_de", 32'(pde), 0);
    chk("c_corner_prev_vs", 32'(pvs), 1);
    chk("c_corner_x", 32'(m_x), 0);
    chk("c_corner_y", 32'(m_y), 0);
    chk("c_corner_de", 32'(m_de), 1);
    chk("c_corner_ls", 32'(m_ls), 1);
    chk("c_corner_pclk", 32'(m_pclk), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
